// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : Front-end controller between the board inputs and the game
//            engines: button debouncing, speed/difficulty priority encoding,
//            game-state machine and the speed-scaled game tick.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK100MHZ     in   system clock, rising edge
//   reset_btn_n   in   asynchronous active-low reset
//   jump_btn      in   raw jump button (asynchronous)
//   pause_btn     in   raw pause button (asynchronous)
//   speed_in      in   speed switch bank [N_SPEED]
//   difficulty_in in   difficulty switch bank [N_DIFF]
//   isdead        in   death flag from physics engine
//   jump          out  debounced jump level
//   jump_pulse    out  one-cycle pulse on debounced jump rising edge
//   tick          out  one-cycle game-step enable
//   start         out  high while in RUN
//   game_start    out  one-cycle pulse on entry to RUN from IDLE or DEAD
//   state         out  IDLE=0 RUN=1 PAUSE=2 DEAD=3
//   speed         out  current accumulator increment [SPD_W]
//   difficulty    out  difficulty latched for the current game [DIFF_W]
// ============================================================================
module game_ctrl #(
  parameter int  DEB_CYCLES = 1000000,
  parameter int  TICK_W     = 25,
  parameter int  TICK_BIT   = 20,
  parameter int  N_SPEED    = 4,
  parameter int  SPEED_BASE = 2,
  parameter int  N_DIFF     = 4,
  localparam int DIFF_W     = (N_DIFF > 2) ? $clog2(N_DIFF) : 1,
  localparam int SPD_W      = $clog2(SPEED_BASE + N_SPEED + 1)
) (
  input  logic                CLK100MHZ,
  input  logic                reset_btn_n,
  input  logic                jump_btn,
  input  logic                pause_btn,
  input  logic [N_SPEED-1:0]  speed_in,
  input  logic [N_DIFF-1:0]   difficulty_in,
  input  logic                isdead,
  output logic                jump,
  output logic                jump_pulse,
  output logic                tick,
  output logic                start,
  output logic                game_start,
  output logic [1:0]          state,
  output logic [SPD_W-1:0]    speed,
  output logic [DIFF_W-1:0]   difficulty
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  // Counter only has to reach DEB_CYCLES-1: the flip happens on the edge
  // that would have taken it to DEB_CYCLES.
  localparam int                    c_DCNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_DCNT_W-1:0]   c_DEB_LAST = c_DCNT_W'(DEB_CYCLES - 1);

  // ------------------------------------------------------------------------
  // Debounce: index 0 = jump, index 1 = pause
  // ------------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_btn_pulse;
  logic       w_jump_lvl;
  logic       w_jump_pulse;
  logic       w_pause_pulse;

  assign w_btn_raw = {pause_btn, jump_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic                r_sync1;
    logic                r_sync2;
    logic                r_deb;
    logic                r_pulse;
    logic [c_DCNT_W-1:0] r_cnt;

    always_ff @(posedge CLK100MHZ or negedge reset_btn_n) begin
      if (!reset_btn_n) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_deb   <= 1'b0;
        r_pulse <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_btn_raw[gi];
        r_sync2 <= r_sync1;
        r_pulse <= 1'b0;
        if (r_sync2 == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DEB_LAST) begin
          r_cnt   <= '0;
          r_deb   <= r_sync2;
          r_pulse <= r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_btn_pulse[gi] = r_pulse;

    // Only the jump level leaves the block; pause is consumed as a pulse.
    if (gi == 0) begin : g_lvl
      assign w_jump_lvl = r_deb;
    end
  end

  assign w_jump_pulse  = w_btn_pulse[0];
  assign w_pause_pulse = w_btn_pulse[1];

  // ------------------------------------------------------------------------
  // Priority encoders: highest set bit wins
  // ------------------------------------------------------------------------
  logic [SPD_W-1:0]  w_speed_enc;
  logic [DIFF_W-1:0] w_diff_enc;

  always_comb begin
    w_speed_enc = SPD_W'(SPEED_BASE);
    for (int i = 0; i < N_SPEED; i++) begin
      if (speed_in[i]) w_speed_enc = SPD_W'(SPEED_BASE + 1 + i);
    end
  end

  always_comb begin
    w_diff_enc = '0;
    for (int i = 0; i < N_DIFF; i++) begin
      if (difficulty_in[i]) w_diff_enc = DIFF_W'(i);
    end
  end

  // ------------------------------------------------------------------------
  // Game-state machine
  // ------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_next;
  logic   w_enter_run;   // entry to RUN from IDLE or DEAD
  logic   w_restart;     // DEAD -> RUN, clears the tick phase

  always_ff @(posedge CLK100MHZ or negedge reset_btn_n) begin
    if (!reset_btn_n) r_state <= ST_IDLE;
    else              r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_enter_run  = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_jump_pulse) begin
          w_state_next = ST_RUN;
          w_enter_run  = 1'b1;
        end
      end
      ST_RUN: begin
        // Death takes priority over a coincident pause request.
        if (isdead)             w_state_next = ST_DEAD;
        else if (w_pause_pulse) w_state_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (w_pause_pulse) w_state_next = ST_RUN;
      end
      ST_DEAD: begin
        if (w_jump_pulse) begin
          w_state_next = ST_RUN;
          w_enter_run  = 1'b1;
          w_restart    = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Speed/difficulty registers, phase accumulator and tick
  // ------------------------------------------------------------------------
  logic [SPD_W-1:0]  r_speed;
  logic [DIFF_W-1:0] r_diff;
  logic [TICK_W-1:0] r_acc;
  logic              r_tick;
  logic              r_game_start;
  logic [TICK_W-1:0] w_acc_inc;
  logic              w_advance;
  logic              w_next_live;

  assign w_acc_inc   = r_acc + TICK_W'(r_speed);
  assign w_advance   = (r_state == ST_IDLE) || (r_state == ST_RUN);
  // Tick is suppressed on the very edge that enters PAUSE or DEAD.
  assign w_next_live = (w_state_next == ST_IDLE) || (w_state_next == ST_RUN);

  always_ff @(posedge CLK100MHZ or negedge reset_btn_n) begin
    if (!reset_btn_n) begin
      r_speed      <= '0;
      r_diff       <= '0;
      r_acc        <= '0;
      r_tick       <= 1'b0;
      r_game_start <= 1'b0;
    end else begin
      r_speed      <= w_speed_enc;
      r_game_start <= w_enter_run;
      if (w_enter_run) r_diff <= w_diff_enc;
      if (w_restart)      r_acc <= '0;
      else if (w_advance) r_acc <= w_acc_inc;
      r_tick <= w_advance & w_next_live & w_acc_inc[TICK_BIT] & ~r_acc[TICK_BIT];
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign jump       = w_jump_lvl;
  assign jump_pulse = w_jump_pulse;
  assign tick       = r_tick;
  assign start      = (r_state == ST_RUN);
  assign game_start = r_game_start;
  assign state      = r_state;
  assign speed      = r_speed;
  assign difficulty = r_diff;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Purpose  : Self-checking bench for game_ctrl with a behavioural reference
//            model (history-window debounce, arithmetic phase, rule-based
//            state updates) and directed plus randomised stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

  localparam int D  = 4;
  localparam int TW = 8;
  localparam int TB = 4;
  localparam int SB = 2;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DEAD  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       jump_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic [3:0] speed_in = 4'd0;
  logic [3:0] diff_in = 4'd0;
  logic       isdead = 1'b0;

  logic       jump, jump_pulse, tick, start, game_start;
  logic [1:0] state;
  logic [2:0] speed;
  logic [1:0] difficulty;

  game_ctrl #(
    .DEB_CYCLES (D),
    .TICK_W     (TW),
    .TICK_BIT   (TB),
    .N_SPEED    (4),
    .SPEED_BASE (SB),
    .N_DIFF     (4)
  ) dut (
    .CLK100MHZ     (clk),
    .reset_btn_n   (rst_n),
    .jump_btn      (jump_btn),
    .pause_btn     (pause_btn),
    .speed_in      (speed_in),
    .difficulty_in (diff_in),
    .isdead        (isdead),
    .jump          (jump),
    .jump_pulse    (jump_pulse),
    .tick          (tick),
    .start         (start),
    .game_start    (game_start),
    .state         (state),
    .speed         (speed),
    .difficulty    (difficulty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_state, m_speed, m_diff, m_acc;
  bit m_jump, m_jp, m_pdeb, m_pp, m_tick, m_gs;
  bit jh[$];
  bit ph[$];

  function automatic int spd_of(logic [3:0] s);
    return (s == 4'd0) ? SB : SB + $clog2(int'(s) + 1);
  endfunction

  function automatic int diff_of(logic [3:0] s);
    return (s == 4'd0) ? 0 : $clog2(int'(s) + 1) - 1;
  endfunction

  // The synchronised value seen at an edge is the raw sample from two edges
  // earlier; the level flips once D such samples in a row disagree with it.
  function automatic bit flips(bit h[$], bit cur);
    bit all_diff = 1'b1;
    for (int k = 0; k < D; k++) begin
      if (h[h.size() - 3 - k] == cur) all_diff = 1'b0;
    end
    return all_diff;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_speed = 0; m_diff = 0; m_acc = 0;
    m_jump = 0; m_jp = 0; m_pdeb = 0; m_pp = 0; m_tick = 0; m_gs = 0;
    jh = {}; ph = {};
    for (int k = 0; k < D + 2; k++) begin
      jh.push_back(1'b0);
      ph.push_back(1'b0);
    end
  endtask

  task automatic model_edge();
    int ns, nacc;
    bit enter, restart, running, ntick, jf, pf;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ns = m_state; enter = 0; restart = 0;
    if (m_state == S_IDLE && m_jp) begin ns = S_RUN; enter = 1; end
    if (m_state == S_DEAD && m_jp) begin ns = S_RUN; enter = 1; restart = 1; end
    if (m_state == S_RUN) begin
      if (isdead)    ns = S_DEAD;
      else if (m_pp) ns = S_PAUSE;
    end
    if (m_state == S_PAUSE && m_pp) ns = S_RUN;

    running = (m_state == S_IDLE) || (m_state == S_RUN);
    if (restart)      nacc = 0;
    else if (running) nacc = (m_acc + m_speed) % (1 << TW);
    else              nacc = m_acc;
    ntick = running && (ns == S_IDLE || ns == S_RUN) &&
            (((nacc >> TB) & 1) == 1) && (((m_acc >> TB) & 1) == 0);

    jh.push_back(jump_btn);  void'(jh.pop_front());
    ph.push_back(pause_btn); void'(ph.pop_front());
    jf = flips(jh, m_jump);
    pf = flips(ph, m_pdeb);
    m_jp   = jf && !m_jump;
    m_pp   = pf && !m_pdeb;
    m_jump = m_jump ^ jf;
    m_pdeb = m_pdeb ^ pf;

    m_gs = enter;
    if (enter) m_diff = diff_of(diff_in);
    m_speed = spd_of(speed_in);
    m_state = ns;
    m_acc   = nacc;
    m_tick  = ntick;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("jump",       32'(jump),       32'(m_jump));
    chk("jump_pulse", 32'(jump_pulse), 32'(m_jp));
    chk("tick",       32'(tick),       32'(m_tick));
    chk("start",      32'(start),      32'(m_state == S_RUN));
    chk("game_start", 32'(game_start), 32'(m_gs));
    chk("state",      32'(state),      32'(m_state));
    chk("speed",      32'(speed),      32'(m_speed));
    chk("difficulty", 32'(difficulty), 32'(m_diff));
  endtask

  // One clock: model advances on the same edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset_pulse();
    #3 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    step();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int cnt, first, pulses, gs_cnt, jleft, pleft;
    model_reset();
    #1 rst_n = 1'b0;
    #1 compare_all();
    chk("rst_state", 32'(state), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("idle_speed", 32'(speed), 32'd2);

    // IDLE tick period 16 with speed 2
    cnt = 0;
    repeat (64) begin step(); cnt += int'(tick); end
    chk("idle_tick_count", 32'(cnt), 32'd4);

    // 3-cycle glitch is discarded
    jump_btn = 1'b1;
    repeat (3) step();
    jump_btn = 1'b0;
    repeat (10) step();
    chk("glitch_jump", 32'(jump), 32'd0);
    chk("glitch_state", 32'(state), 32'd0);

    // Held press starts the game
    diff_in = 4'b0110;
    jump_btn = 1'b1;
    first = 0; pulses = 0; gs_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (jump_pulse && first == 0) first = c;
      pulses += int'(jump_pulse);
      gs_cnt += int'(game_start);
    end
    jump_btn = 1'b0;
    chk("jump_latency", 32'(first), 32'd6);
    chk("jump_pulse_count", 32'(pulses), 32'd1);
    chk("game_start_count", 32'(gs_cnt), 32'd1);
    chk("run_state", 32'(state), 32'd1);
    chk("diff_latched", 32'(difficulty), 32'd2);

    // Mid-game switch changes
    diff_in  = 4'b1000;
    speed_in = 4'b0010;
    repeat (10) step();
    chk("diff_held", 32'(difficulty), 32'd2);
    chk("run_speed", 32'(speed), 32'd4);
    cnt = 0;
    repeat (32) begin step(); cnt += int'(tick); end
    chk("run_tick_count", 32'(cnt), 32'd4);

    // Pause, tick stops, then resume
    pause_btn = 1'b1;
    repeat (6) step();
    pause_btn = 1'b0;
    repeat (6) step();
    chk("pause_state", 32'(state), 32'd2);
    cnt = 0;
    repeat (20) begin step(); cnt += int'(tick); end
    chk("pause_tick_count", 32'(cnt), 32'd0);
    pause_btn = 1'b1;
    repeat (6) step();
    pause_btn = 1'b0;
    repeat (12) step();
    chk("resume_state", 32'(state), 32'd1);

    // isdead coincident with a pause pulse: DEAD wins
    pause_btn = 1'b1;
    repeat (6) step();
    isdead = 1'b1;
    step();
    isdead = 1'b0;
    pause_btn = 1'b0;
    chk("dead_state", 32'(state), 32'd3);
    chk("dead_tick", 32'(tick), 32'd0);
    repeat (12) step();

    // Restart from DEAD re-latches difficulty
    jump_btn = 1'b1;
    gs_cnt = 0;
    repeat (10) begin step(); gs_cnt += int'(game_start); end
    jump_btn = 1'b0;
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_diff", 32'(difficulty), 32'd3);
    chk("restart_gs_count", 32'(gs_cnt), 32'd1);
    repeat (20) step();

    // Asynchronous reset mid-game
    async_reset_pulse();
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_diff", 32'(difficulty), 32'd0);
    repeat (5) step();

    // Randomised phase
    jleft = 0; pleft = 0;
    for (int c = 0; c < 1500; c++) begin
      if (jleft == 0) begin
        jump_btn = 1'($urandom_range(0, 1));
        jleft = int'($urandom_range(1, 12));
      end
      if (pleft == 0) begin
        pause_btn = 1'($urandom_range(0, 1));
        pleft = int'($urandom_range(1, 12));
      end
      jleft--; pleft--;
      isdead = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) speed_in = 4'($urandom);
      if ($urandom_range(0, 49) == 0) diff_in  = 4'($urandom);
      if ($urandom_range(0, 399) == 0) async_reset_pulse();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
# game_ctrl

Parametrised front-end controller between the board inputs and the game engines. It handles:
- debouncing of the jump and pause buttons;
- priority encoding of the speed and difficulty switch banks;
- a game-state machine (IDLE/RUN/PAUSE/DEAD);
- the speed-scaled game tick that clocks the physics, map and score engines as a one-cycle enable in the CLK100MHZ domain.

It replaces the ad-hoc start/jump/divider logic in the top level.

## Interface
- DEB_CYCLES, 1000000: consecutive stable cycles required before a debounced button changes.
- TICK_W, 25: width of the tick phase accumulator.
- TICK_BIT, 20: accumulator bit whose 0->1 transition produces a tick; must be < TICK_W.
- N_SPEED, 4: width of speed_in.
- SPEED_BASE, 2: speed value with no speed switch set.
- N_DIFF, 4: width of difficulty_in; DIFF_W = max(1, clog2(N_DIFF)).
- SPD_W = clog2(SPEED_BASE+N_SPEED+1) (derived).
- CLK100MHZ  in  1  system clock, all logic on rising edge.
- reset_btn_n  in  1  asynchronous, active-low reset.
- jump_btn  in  1  raw jump button, asynchronous.
- pause_btn  in  1  raw pause button, asynchronous.
- speed_in  in  N_SPEED  speed switches.
- difficulty_in  in  N_DIFF  difficulty switches.
- isdead  in  1  death flag from physics engine, synchronous.
- jump  out  1  debounced jump level (feeds audio and physics).
- jump_pulse  out  1  one-cycle pulse on debounced jump rising edge.
- tick  out  1  one-cycle game-step enable.
- start  out  1  high while state is RUN.
- game_start  out  1  one-cycle pulse on any entry to RUN from IDLE or DEAD.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DEAD=3.
- speed  out  SPD_W  current accumulator increment.
- difficulty  out  DIFF_W  difficulty latched for the current game.

## Operation
- Reset (reset_btn_n low, async): all outputs 0, state IDLE, accumulator 0, debounce counters 0, synchronisers 0. speed reads SPEED_BASE from the first edge after release.
- Debounce, per button: 2-flop synchroniser, then a counter that runs while the synchronised value differs from the debounced value and clears whenever they match. The debounced value flips on the edge at which the counter reaches DEB_CYCLES. Any shorter glitch is discarded.
- pause_pulse is internal, formed the same way as jump_pulse.
- Speed encode, registered every cycle: highest set bit i of speed_in gives SPEED_BASE+1+i; no bit set gives SPEED_BASE.
- Difficulty encode: highest set bit i of difficulty_in gives i; no bit set gives 0. The encoded value is captured into difficulty only on the edge that enters RUN from IDLE or DEAD. Switch changes mid-game have no effect.
- State machine:
  - IDLE --jump_pulse--> RUN
  - RUN --isdead--> DEAD
  - RUN --pause_pulse--> PAUSE
  - PAUSE --pause_pulse--> RUN
  - DEAD --jump_pulse--> RUN (restart)
- Rules within the state machine:
  - isdead is ignored outside RUN.
  - jump_pulse is ignored in RUN and PAUSE. It still appears on the jump_pulse output for the physics engine.
  - In RUN, simultaneous isdead and pause_pulse: DEAD wins.
  - pause_pulse in IDLE or DEAD is ignored.
- Accumulator:
  - acc <= acc + speed in IDLE and RUN; held in PAUSE and DEAD.
  - Wraps modulo 2^TICK_W.
  - Cleared to 0 on the DEAD->RUN transition. IDLE->RUN keeps it.
- tick is registered and equals (acc[TICK_BIT] rose on the previous edge). It is never high in PAUSE or DEAD, and is forced low on the edge that enters PAUSE or DEAD.

## Timing
- jump_btn first sampled high at edge k and held: jump and jump_pulse go high after edge k+DEB_CYCLES+1. jump_pulse lasts exactly 1 cycle.
- State update is registered: state changes on the edge after jump_pulse, pause_pulse or isdead is sampled high.
- start and game_start change in the same cycle as state.
- Tick period is 2^(TICK_BIT+1)/speed cycles, exact when speed divides 2^(TICK_BIT+1).
- A speed change takes effect on the increment 1 cycle after the switch is sampled. No tick glitch is produced; the phase simply continues.
- Reset mid-game returns to IDLE immediately. difficulty clears to 0.

## Test plan
Directed tests run with DEB_CYCLES=4, TICK_W=8, TICK_BIT=4.
- Reset, then speed_in=0 in IDLE -> speed=2, tick every 16 cycles; state=0, start=0.
- jump_btn high for 3 cycles then low -> no jump, no state change. Held for 10 cycles -> jump high 5 edges after first sample, single jump_pulse, state=RUN, game_start 1 cycle.
- difficulty_in=4'b0110 at start, then changed to 4'b1000 in RUN -> difficulty stays 2. speed_in=4'b0010 -> speed=4, tick every 8 cycles.
- RUN, pause_btn pulse -> state=PAUSE, tick stops, acc frozen. Second pause -> RUN, ticks resume from the frozen phase.
- RUN, isdead and a debounced pause_pulse in the same cycle -> state=DEAD, tick 0. Then jump -> RUN, acc=0, game_start=1, difficulty re-latched.
- reset_btn_n low for 1 cycle mid-RUN, asynchronous to the clock -> all outputs 0 before the next edge, state=IDLE.
